iob_axi2ibex: RTL and testbench

IOB_AXI2IBEX -- requirements
Module: iob_axi2ibex

---
 rtl/iob_axi2ibex.sv | 218 +++++++++++++++++++++
 tb/tb_iob_axi2ibex.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi2ibex.sv
// AXI4-Lite slave to Ibex-style memory request/response bridge.
// One holding register per AW/W/AR channel and one memory transaction in
// flight at a time. Optional build macro IOB_AXI2IBEX_RR_ARB_EN selects
// round-robin read/write arbitration; without it a pending write always wins.
//
// Handshake semantics: every AXI channel transfers on a rising clk_i edge where
// valid and ready are both high (and cke_i=1). The memory side follows the Ibex
// protocol: mem_req_o and its qualifiers hold steady until mem_gnt_i, and
// exactly one mem_rvalid_i pulse returns per granted request.
module iob_axi2ibex #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [AXI_ADDR_W-3:0]   awaddr_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [AXI_DATA_W-1:0]   wdata_i,
  input  logic [AXI_DATA_W/8-1:0] wstrb_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [AXI_ADDR_W-3:0]   araddr_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [AXI_DATA_W-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AXI_DATA_W/8-1:0] mem_be_o,
  output logic [AXI_ADDR_W-3:0]   mem_addr_o,
  output logic [AXI_DATA_W-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [AXI_DATA_W-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int AW = AXI_ADDR_W - 2;
  localparam int SW = AXI_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ, WR_WAIT, WR_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            aw_full_q, aw_full_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            w_full_q, w_full_d;
  logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
  logic [SW-1:0]   w_strb_q, w_strb_d;
  logic            ar_full_q, ar_full_d;
  logic [AW-1:0]   ar_addr_q, ar_addr_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
`ifdef IOB_AXI2IBEX_RR_ARB_EN
  logic            last_rd_q, last_rd_d;
`endif

  logic   wr_elig, rd_elig, pick_wr;
  state_t out_state;

  // Outputs are decoded from the state register, forced to IDLE during reset
  // so that everything (readys included) reads 0 while rst_i is high.
  always_comb begin
    out_state   = rst_i ? IDLE : state_q;
    awready_o   = ~aw_full_q & ~rst_i;
    wready_o    = ~w_full_q & ~rst_i;
    arready_o   = ~ar_full_q & ~rst_i;
    mem_req_o   = (out_state == RD_REQ) || (out_state == WR_REQ);
    mem_we_o    = (out_state == WR_REQ);
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (out_state == RD_REQ) begin
      mem_be_o   = '1;
      mem_addr_o = ar_addr_q;
    end else if (out_state == WR_REQ) begin
      mem_be_o    = w_strb_q;
      mem_addr_o  = aw_addr_q;
      mem_wdata_o = w_data_q;
    end
    rvalid_o = (out_state == RD_RESP);
    rdata_o  = rvalid_o ? rdata_q : '0;
    rresp_o  = rvalid_o ? resp_q : 2'b00;
    bvalid_o = (out_state == WR_RESP);
    bresp_o  = bvalid_o ? resp_q : 2'b00;
  end

  // Arbitration between a complete write (AW+W) and a held read.
  always_comb begin
    wr_elig = aw_full_q & w_full_q;
    rd_elig = ar_full_q;
`ifdef IOB_AXI2IBEX_RR_ARB_EN
    pick_wr = wr_elig & (~rd_elig | last_rd_q);
`else
    pick_wr = wr_elig;
`endif
  end

  // Next-state logic: FSM transitions, holding-register fill and release.
  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifdef IOB_AXI2IBEX_RR_ARB_EN
    last_rd_d = last_rd_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_wr) begin
`ifdef IOB_AXI2IBEX_RR_ARB_EN
          last_rd_d = 1'b0;
`endif
          if (w_strb_q == '0) begin
            // Nothing to write: answer OKAY without touching memory.
            resp_d    = 2'b00;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            state_d   = WR_RESP;
          end else begin
            state_d = WR_REQ;
          end
        end else if (rd_elig) begin
`ifdef IOB_AXI2IBEX_RR_ARB_EN
          last_rd_d = 1'b1;
`endif
          state_d = RD_REQ;
        end
      end
      RD_REQ: if (mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d   = mem_rdata_i;
          resp_d    = mem_err_i ? 2'b10 : 2'b00;
          ar_full_d = 1'b0;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: if (rready_i) state_d = IDLE;
      WR_REQ: if (mem_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (mem_rvalid_i) begin
          resp_d    = mem_err_i ? 2'b10 : 2'b00;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: if (bready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A register can only accept when empty, and is only released when
    // full, so fill and release never collide in the same cycle.
    if (awvalid_i && awready_o) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr_i;
    end
    if (wvalid_i && wready_o) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end
    if (arvalid_i && arready_o) begin
      ar_full_d = 1'b1;
      ar_addr_d = araddr_i;
    end
  end

  // State registers: reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
`ifdef IOB_AXI2IBEX_RR_ARB_EN
      last_rd_q <= 1'b1;
`endif
    end else if (cke_i) begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef IOB_AXI2IBEX_RR_ARB_EN
      last_rd_q <= last_rd_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_axi2ibex.sv
// Directed bench for iob_axi2ibex with an expected-response queue.
module tb_iob_axi2ibex;

  localparam int AW = 30;

  // Clock and reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          cke_i, rst_i;
  logic          awvalid_i, awready_o, wvalid_i, wready_o;
  logic [AW-1:0] awaddr_i, araddr_i, mem_addr_o;
  logic [31:0]   wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]    wstrb_i, mem_be_o;
  logic          bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
  logic [1:0]    bresp_o, rresp_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;

  iob_axi2ibex #(.AXI_ADDR_W(32), .AXI_DATA_W(32)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  // Scoreboard: {resp, data}; writes use data 0
  logic [33:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    arvalid_i = 1'b1; araddr_i = a;
    while (!arready_o && n < 50) begin tick(); n++; end
    chk("ar_accept", arready_o, 1);
    tick();
    arvalid_i = 1'b0;
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    awvalid_i = 1'b1; awaddr_i = a;
    while (!awready_o && n < 50) begin tick(); n++; end
    chk("aw_accept", awready_o, 1);
    tick();
    awvalid_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wvalid_i = 1'b1; wdata_i = d; wstrb_i = s;
    while (!wready_o && n < 50) begin tick(); n++; end
    chk("w_accept", wready_o, 1);
    tick();
    wvalid_i = 1'b0;
  endtask

  // Memory responder: checks the request, grants after gdly cycles, answers next cycle
  task automatic serve(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                       input logic [31:0] wd, input int gdly,
                       input logic [31:0] rd, input logic err);
    int n = 0;
    while (!mem_req_o && n < 50) begin tick(); n++; end
    chk("mem_req", mem_req_o, 1);
    chk("mem_we", mem_we_o, we);
    chk("mem_be", mem_be_o, be);
    chk("mem_addr", mem_addr_o, a);
    chk("mem_wdata", mem_wdata_o, wd);
    for (int d = 0; d < gdly; d++) begin
      tick();
      chk("req_hold", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b1, we, be, a, wd});
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("req_drop", mem_req_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = rd; mem_err_i = err;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
  endtask

  // Scoreboard pop/compare on R and B beats
  task automatic collect_r(input int rdly);
    int n = 0;
    logic [33:0] obs, exp;
    while (!rvalid_o && n < 50) begin tick(); n++; end
    chk("rvalid", rvalid_o, 1);
    obs = {rresp_o, rdata_o};
    for (int d = 0; d < rdly; d++) begin
      tick();
      chk("r_hold", {rvalid_o, rresp_o, rdata_o}, {1'b1, obs});
    end
    chk("sb_has_r", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("r_beat", obs, exp);
    end
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
    chk("rvalid_drop", rvalid_o, 0);
  endtask

  task automatic collect_b();
    int n = 0;
    logic [33:0] obs, exp;
    while (!bvalid_o && n < 50) begin tick(); n++; end
    chk("bvalid", bvalid_o, 1);
    obs = {bresp_o, 32'h0};
    chk("sb_has_b", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("b_beat", obs, exp);
    end
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    chk("bvalid_drop", bvalid_o, 0);
  endtask

  // Load every empty holding register in one cycle
  task automatic fill(input int i);
    if (arready_o) begin arvalid_i = 1'b1; araddr_i = 30'h40; end
    if (awready_o) begin awvalid_i = 1'b1; awaddr_i = 30'h50; end
    if (wready_o)  begin wvalid_i = 1'b1; wdata_i = 32'hB0 + i; wstrb_i = 4'hF; end
    tick();
    arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0;
  endtask

  task automatic serve_any(input logic exp_we, input logic [31:0] rd);
    int n = 0;
    while (!mem_req_o && n < 50) begin tick(); n++; end
    chk("sat_req", mem_req_o, 1);
    chk("sat_order", mem_we_o, exp_we);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = rd;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic order[4];
    logic drain_we;
    logic saw;
    int n;
`ifdef IOB_AXI2IBEX_RR_ARB_EN
    order = '{1'b1, 1'b0, 1'b1, 1'b0};
    drain_we = 1'b1;
`else
    order = '{1'b1, 1'b1, 1'b1, 1'b1};
    drain_we = 1'b0;
`endif
    cke_i = 1'b1; rst_i = 1'b1;
    awvalid_i = 0; awaddr_i = '0; wvalid_i = 0; wdata_i = '0; wstrb_i = '0;
    bready_i = 0; arvalid_i = 0; araddr_i = '0; rready_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_awready", awready_o, 0);
    chk("rst_wready", wready_o, 0);
    chk("rst_arready", arready_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_valids", {rvalid_o, bvalid_o}, 2'b00);
    rst_i = 1'b0;
    tick();
    chk("idle_readys", {awready_o, wready_o, arready_o}, 3'b111);

    // Basic read with latency checks
    exp_q.push_back({2'b00, 32'hDEADBEEF});
    send_ar(30'h10);
    chk("lat_n1_req", mem_req_o, 0);
    chk("ar_held_ready", arready_o, 0);
    tick();
    chk("lat_n2_req", mem_req_o, 1);
    serve(1'b0, 4'hF, 30'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    chk("r_latency", rvalid_o, 1);
    collect_r(0);

    // W first, AW three cycles later
    exp_q.push_back({2'b00, 32'h0});
    send_w(32'h12345678, 4'h3);
    tick(); tick();
    chk("w_only_no_req", mem_req_o, 0);
    send_aw(30'h20);
    serve(1'b1, 4'h3, 30'h20, 32'h12345678, 0, 32'h0, 1'b0);
    collect_b();

    // Error responses
    exp_q.push_back({2'b10, 32'h5555AAAA});
    send_ar(30'h8);
    serve(1'b0, 4'hF, 30'h8, 32'h0, 0, 32'h5555AAAA, 1'b1);
    collect_r(0);
    exp_q.push_back({2'b10, 32'h0});
    send_aw(30'h9);
    send_w(32'h1, 4'hF);
    serve(1'b1, 4'hF, 30'h9, 32'h1, 0, 32'h0, 1'b1);
    collect_b();

    // Zero strobe: no memory request, OKAY
    exp_q.push_back({2'b00, 32'h0});
    send_w(32'hCAFE, 4'h0);
    send_aw(30'h30);
    saw = 1'b0; n = 0;
    while (!bvalid_o && n < 20) begin saw |= mem_req_o; tick(); n++; end
    saw |= mem_req_o;
    chk("zs_no_req", saw, 0);
    collect_b();

    // Slow grant and slow R ready
    exp_q.push_back({2'b00, 32'h0BADF00D});
    send_ar(30'h3FF);
    chk("ar_held_ready2", arready_o, 0);
    serve(1'b0, 4'hF, 30'h3FF, 32'h0, 5, 32'h0BADF00D, 1'b0);
    chk("ar_freed_in_resp", arready_o, 1);
    collect_r(4);

    // Saturated traffic: arbitration order
    fill(0);
    for (int i = 0; i < 4; i++) begin
      if (order[i]) exp_q.push_back({2'b00, 32'h0});
      else exp_q.push_back({2'b00, 32'hA0 + i});
      serve_any(order[i], 32'hA0 + i);
      if (i < 3) fill(i + 1);
      if (order[i]) collect_b();
      else collect_r(0);
    end
    if (drain_we) exp_q.push_back({2'b00, 32'h0});
    else exp_q.push_back({2'b00, 32'hC0});
    serve_any(drain_we, 32'hC0);
    if (drain_we) collect_b();
    else collect_r(0);

    // Reset while waiting for the memory response
    send_ar(30'h7);
    n = 0;
    while (!mem_req_o && n < 50) begin tick(); n++; end
    chk("rw_req", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("rw_rst_readys", {awready_o, wready_o, arready_o}, 3'b000);
    chk("rw_rst_req", mem_req_o, 0);
    tick();
    rst_i = 1'b0;
    chk("rw_post_req", mem_req_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin saw |= rvalid_o | mem_req_o; tick(); end
    chk("rw_no_r", saw, 0);
    chk("rw_ar_empty", arready_o, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
